// File: rtl/router_pkt_fifo_if.sv
// Router packet FIFO port bundle.
// Write side, read side and status flags.
interface router_pkt_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int AW = $clog2(DEPTH);

  logic                  soft_reset;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  write_enb;
  logic                  lfd_state;
  logic                  read_enb;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  rd_sop;
  logic                  rd_eop;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic [AW:0]           fill_level;
  logic [AW:0]           pkt_count;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output soft_reset, data_in, write_enb,
    output lfd_state, read_enb,
    input  data_out, rd_sop, rd_eop,
    input  full, empty, almost_full,
    input  fill_level, pkt_count,
    input  overflow, underflow
  );

  modport slave (
    input  soft_reset, data_in, write_enb,
    input  lfd_state, read_enb,
    output data_out, rd_sop, rd_eop,
    output full, empty, almost_full,
    output fill_level, pkt_count,
    output overflow, underflow
  );
endinterface

// File: rtl/router_pkt_fifo.sv
// Packet-aware router output FIFO.
// Tracks headers, packet tail and fill level.
module router_pkt_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AFULL_TH   = DEPTH - 2,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic            clock,
  input  logic            resetn,
  router_pkt_fifo_if.slave bus
);

  localparam int RW = DATA_WIDTH - 1;

  logic [DATA_WIDTH:0]   mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [AW:0]           fill_q;
  logic [AW:0]           pkt_q;
  logic [RW-1:0]         rem;
  logic [DATA_WIDTH:0]   rd_word;
  logic                  rd_hdr;
  logic                  live;
  logic                  wr_go;
  logic                  rd_go;

  assign live    = resetn & ~bus.soft_reset;
  assign wr_go   = live & bus.write_enb & ~bus.full;
  assign rd_go   = live & bus.read_enb & ~bus.empty;
  assign rd_word = mem[rd_ptr];
  assign rd_hdr  = rd_word[DATA_WIDTH];

  assign bus.fill_level  = fill_q;
  assign bus.pkt_count   = pkt_q;
  assign bus.full        = (fill_q == (AW+1)'(DEPTH));
  assign bus.empty       = (fill_q == '0);
  assign bus.almost_full = (fill_q >= (AW+1)'(AFULL_TH));

  // Storage array; contents survive reset.
  always_ff @(posedge clock) begin
    if (wr_go)
      mem[wr_ptr] <= {bus.lfd_state, bus.data_in};
  end

  // Pointers, counters, read register and sticky flags.
  always_ff @(posedge clock) begin
    if (!resetn || bus.soft_reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fill_q        <= '0;
      pkt_q         <= '0;
      rem           <= '0;
      bus.data_out  <= '0;
      bus.rd_sop    <= 1'b0;
      bus.rd_eop    <= 1'b0;
      bus.overflow  <= 1'b0;
      bus.underflow <= 1'b0;
    end else begin
      if (bus.write_enb && bus.full)
        bus.overflow <= 1'b1;
      if (bus.read_enb && bus.empty)
        bus.underflow <= 1'b1;
      if (wr_go)
        wr_ptr <= wr_ptr + 1'b1;
      fill_q <= fill_q
              + (AW+1)'(wr_go)
              - (AW+1)'(rd_go);
      pkt_q  <= pkt_q
              + (AW+1)'(wr_go & bus.lfd_state)
              - (AW+1)'(rd_go & rd_hdr);
      bus.rd_eop <= rd_go && (rem == RW'(1));
      if (rd_go) begin
        rd_ptr       <= rd_ptr + 1'b1;
        bus.data_out <= rd_word[DATA_WIDTH-1:0];
        bus.rd_sop   <= rd_hdr;
        if (rd_hdr)
          rem <= RW'(rd_word[DATA_WIDTH-1:2])
               + RW'(1);
        else if (rem != '0)
          rem <= rem - RW'(1);
      end
    end
  end

endmodule

// File: tb/tb_router_pkt_fifo.sv
// Randomized scoreboard bench for router_pkt_fifo.
// Model is a queue of tagged packet words.
module tb_router_pkt_fifo;

  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AFT   = DEPTH - 2;
  localparam int AW    = $clog2(DEPTH);

  typedef struct {
    bit       lfd;
    bit       eop;
    bit [7:0] d;
  } word_t;

  logic clock;
  logic resetn;

  router_pkt_fifo_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  router_pkt_fifo #(
    .DATA_WIDTH(DW),
    .DEPTH(DEPTH),
    .AFULL_TH(AFT)
  ) dut (
    .clock (clock),
    .resetn(resetn),
    .bus   (bus.slave)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  word_t q[$];
  word_t exp_q[$];
  bit    m_ov, m_un;
  bit [7:0] m_dout;
  bit    m_sop;
  int    gen_left;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               name, act, req);
    end
  endtask

  function automatic int pkts();
    int n = 0;
    foreach (q[i]) if (q[i].lfd) n++;
    return n;
  endfunction

  // Monitor: every accepted read must match the scoreboard head.
  initial begin
    bit acc;
    word_t e;
    forever begin
      @(negedge clock);
      acc = resetn && !bus.soft_reset
            && bus.read_enb && !bus.empty;
      @(posedge clock);
      #1;
      if (acc) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_read", 1, 0);
        end else begin
          e = exp_q.pop_front();
          chk("data_out", int'(bus.data_out), int'(e.d));
          chk("rd_sop", int'(bus.rd_sop), int'(e.lfd));
          chk("rd_eop", int'(bus.rd_eop), int'(e.eop));
        end
      end
    end
  end

  task automatic step(input bit we, input bit re,
                      input bit lfd, input bit eop,
                      input bit [7:0] d, input bit sr,
                      output bit wacc);
    bit fm, em, rd;
    word_t w;
    bus.write_enb  = we;
    bus.read_enb   = re;
    bus.lfd_state  = lfd;
    bus.data_in    = d;
    bus.soft_reset = sr;
    fm = (q.size() == DEPTH);
    em = (q.size() == 0);
    rd = 1'b0;
    wacc = 1'b0;
    if (sr) begin
      q.delete();
      m_ov = 0; m_un = 0;
      m_dout = 0; m_sop = 0;
    end else begin
      if (we && fm) m_ov = 1;
      if (re && em) m_un = 1;
      rd = re && !em;
      wacc = we && !fm;
      if (rd) begin
        w = q.pop_front();
        exp_q.push_back(w);
        m_dout = w.d;
        m_sop = w.lfd;
      end
      if (wacc) q.push_back('{lfd, eop, d});
    end
    @(posedge clock);
    #1;
    chk("fill_level", int'(bus.fill_level), q.size());
    chk("pkt_count", int'(bus.pkt_count), pkts());
    chk("full", int'(bus.full), int'(q.size() == DEPTH));
    chk("empty", int'(bus.empty), int'(q.size() == 0));
    chk("almost_full", int'(bus.almost_full),
        int'(q.size() >= AFT));
    chk("overflow", int'(bus.overflow), int'(m_ov));
    chk("underflow", int'(bus.underflow), int'(m_un));
    if (!rd) begin
      chk("hold_data", int'(bus.data_out), int'(m_dout));
      chk("hold_sop", int'(bus.rd_sop), int'(m_sop));
      chk("idle_eop", int'(bus.rd_eop), 0);
    end
  endtask

  task automatic idle();
    bit a;
    step(0, 0, 0, 0, 8'h00, 0, a);
  endtask

  task automatic wr(input bit lfd, input bit eop,
                    input bit [7:0] d);
    bit a;
    step(1, 0, lfd, eop, d, 0, a);
  endtask

  task automatic rdw();
    bit a;
    step(0, 1, 0, 0, 8'h00, 0, a);
  endtask

  initial begin
    bit a;
    bit [7:0] d;
    bit lfd, eop, we, re, sr;
    int len;

    resetn = 1'b0;
    bus.soft_reset = 1'b0;
    bus.write_enb  = 1'b1;
    bus.data_in    = 8'hAA;
    bus.lfd_state  = 1'b1;
    bus.read_enb   = 1'b0;
    m_ov = 0; m_un = 0; m_dout = 0; m_sop = 0;
    @(posedge clock);
    #1;
    chk("rst_empty", int'(bus.empty), 1);
    chk("rst_full", int'(bus.full), 0);
    chk("rst_afull", int'(bus.almost_full), 0);
    chk("rst_fill", int'(bus.fill_level), 0);
    chk("rst_pkt", int'(bus.pkt_count), 0);
    chk("rst_dout", int'(bus.data_out), 0);
    chk("rst_eop", int'(bus.rd_eop), 0);
    chk("rst_ov", int'(bus.overflow), 0);
    resetn = 1'b1;
    idle();

    wr(1, 0, 8'h39);
    for (int i = 0; i < 14; i++)
      wr(0, 0, 8'($urandom));
    wr(0, 1, 8'($urandom));
    for (int i = 0; i < 16; i++) rdw();
    idle();

    for (int i = 0; i < 17; i++)
      wr(0, 0, 8'(8'h10 + i));
    step(1, 1, 0, 0, 8'hE1, 0, a);
    step(1, 1, 0, 0, 8'hE2, 0, a);
    for (int i = 0; i < 16; i++) rdw();
    idle();

    rdw();
    wr(1, 0, 8'h02);
    wr(0, 1, 8'h5C);
    rdw();
    rdw();
    idle();

    wr(1, 0, 8'h05);
    wr(0, 0, 8'h71);
    wr(0, 0, 8'h72);
    step(0, 0, 0, 0, 8'h00, 1, a);
    chk("sr_dout", int'(bus.data_out), 0);
    wr(1, 0, 8'h00);
    wr(0, 1, 8'h9D);
    rdw();
    rdw();
    idle();

    gen_left = 0;
    len = 0;
    for (int c = 0; c < 3000; c++) begin
      we = ($urandom_range(0, 9) < 6);
      re = ($urandom_range(0, 9) < 5);
      sr = ($urandom_range(0, 199) == 0);
      d = 8'($urandom);
      lfd = 0;
      eop = 0;
      if (gen_left == 0) begin
        len = $urandom_range(0, 5);
        d = {6'(len), d[1:0]};
        lfd = 1;
      end else begin
        eop = (gen_left == 1);
      end
      step(we, re, lfd, eop, d, sr, a);
      if (sr) gen_left = 0;
      else if (a) begin
        if (lfd) gen_left = len + 1;
        else gen_left--;
      end
    end

    for (int i = 0; i < DEPTH + 1; i++) rdw();
    idle();
    idle();
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
